// File: rtl/accel_top.sv
// accel_top: memory-mapped compute accelerator.
// 8-entry register file (A, B, C, D, CTRL, STATUS, RES_LO, RES_HI) plus a
// sequential engine computing ADD (1 cycle), MAC (2N cycles, shift-add) and
// DIV (N cycles, restoring division).
// Optional build macro RF_RDATA_REG_EN: registers o_data (one-cycle read latency).
module accel_top #(
    parameter int N              = 32,
    parameter int RF_Addr_BITNES = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [RF_Addr_BITNES-1:0] i_addr,
    input  logic [N-1:0]              i_data,
    input  logic                      i_RF_WE,
    output logic [N-1:0]              o_data
);

    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MAC = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Host-visible registers
    logic [N-1:0] a_q, b_q, c_q, d_q;
    op_e          op_q;
    logic         busy_q, done_q, dz_q;
    logic [N-1:0] res_lo_q, res_hi_q;

    // Engine working state. wa/wb are multiplicand/multiplier for MAC and
    // quotient-shift/divisor for DIV; acc holds the ADD sum or MAC total.
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  acc_q, wa_q, wb_q, rem_q;
    logic [N-1:0]  cap_c_q, cap_d_q;

    logic [2:0]    sel;
    logic          wr_en, start;
    op_e           new_op;
    logic          unused_addr_bits;

    assign sel              = i_addr[2:0];
    assign unused_addr_bits = ^i_addr[RF_Addr_BITNES-1:3];
    assign wr_en            = i_RF_WE && !busy_q;
    assign new_op           = op_e'(i_data[2:1]);
    assign start            = wr_en && (sel == 3'd4) && i_data[0] && (new_op != OP_RSV);

    // One step of the MAC and DIV datapaths
    logic [N-1:0] mac_sum_d;
    logic [N:0]   div_shift, div_rem_d;
    logic         div_ge;
    logic [N-1:0] div_quo_d;

    always_comb begin
        mac_sum_d = acc_q + (wb_q[0] ? wa_q : '0);
        div_shift = {rem_q, wa_q[N-1]};
        div_ge    = (div_shift >= {1'b0, wb_q});
        div_rem_d = div_ge ? (div_shift - {1'b0, wb_q}) : div_shift;
        div_quo_d = {wa_q[N-2:0], div_ge};
    end

    // Operand and OP registers: host writes, blocked while the engine runs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
            op_q <= OP_ADD;
        end else if (wr_en) begin
            case (sel)
                3'd0:    a_q  <= i_data;
                3'd1:    b_q  <= i_data;
                3'd2:    c_q  <= i_data;
                3'd3:    d_q  <= i_data;
                3'd4:    op_q <= new_op;
                default: ;
            endcase
        end
    end

    // Engine: launch on accepted start, step once per cycle, publish results
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
            rem_q    <= '0;
            cap_c_q  <= '0;
            cap_d_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            // ADD is finished in one step, so its sum is formed right here
            acc_q   <= (new_op == OP_ADD) ? (a_q + b_q + c_q + d_q) : '0;
            wa_q    <= a_q;
            wb_q    <= b_q;
            cap_c_q <= c_q;
            cap_d_q <= d_q;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            case (op_q)
                OP_MAC: begin
                    acc_q <= mac_sum_d;
                    if (cnt_q == CW'(N - 1)) begin
                        // A*B done, switch to the captured C*D pair
                        wa_q <= cap_c_q;
                        wb_q <= cap_d_q;
                    end else begin
                        wa_q <= wa_q << 1;
                        wb_q <= wb_q >> 1;
                    end
                    if (cnt_q == CW'(2 * N - 1)) begin
                        res_lo_q <= mac_sum_d;
                        res_hi_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                OP_DIV: begin
                    rem_q <= div_rem_d[N-1:0];
                    wa_q  <= div_quo_d;
                    if (cnt_q == CW'(N - 1)) begin
                        // A zero divisor makes every trial subtract succeed,
                        // which yields quotient all-ones and remainder A.
                        res_lo_q <= div_quo_d;
                        res_hi_q <= div_rem_d[N-1:0];
                        dz_q     <= (wb_q == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    res_lo_q <= acc_q;
                    res_hi_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
            endcase
        end
    end

    // Register read mux; START always reads back 0
    logic [N-1:0] rdata;

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0: rdata = a_q;
            3'd1: rdata = b_q;
            3'd2: rdata = c_q;
            3'd3: rdata = d_q;
            3'd4: rdata = {{(N-3){1'b0}}, op_q, 1'b0};
            3'd5: rdata = {{(N-3){1'b0}}, dz_q, done_q, busy_q};
            3'd6: rdata = res_lo_q;
            3'd7: rdata = res_hi_q;
            default: rdata = '0;
        endcase
    end

`ifdef RF_RDATA_REG_EN
    logic [N-1:0] o_data_q;

    // Registered read port: one cycle of read latency
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) o_data_q <= '0;
        else          o_data_q <= rdata;
    end

    assign o_data = o_data_q;
`else
    assign o_data = rdata;
`endif

endmodule

// File: tb/tb_accel_top.sv
// Bench for accel_top: table of directed vectors, hand-written sequences for
// busy-write blocking, reserved OP and mid-operation reset, then random ops
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_accel_top;
    localparam int N = 32;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [31:0]   i_addr;
    logic [N-1:0]  i_data;
    logic          i_RF_WE;
    logic [N-1:0]  o_data;

    int n_cmp = 0;
    int n_bad = 0;

    accel_top #(.N(N), .RF_Addr_BITNES(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_RF_WE (i_RF_WE),
        .o_data  (o_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a, b, c, d;
        logic [N-1:0] lo, hi, st;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [N-1:0] data);
        i_addr  = addr;
        i_data  = data;
        i_RF_WE = 1'b1;
        @(posedge i_clk);
        #1;
        i_RF_WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [N-1:0] v);
        i_addr = addr;
        #1;
        v = o_data;
    endtask

    // Reference: results straight from the arithmetic definitions
    task automatic model(input vec_t in, output vec_t o);
        o = in;
        o.hi = '0;
        o.st = 32'h2;
        case (in.op)
            2'b00: begin o.lo = in.a + in.b + in.c + in.d; o.lat = 1; end
            2'b01: begin o.lo = in.a * in.b + in.c * in.d; o.lat = 2 * N; end
            default: begin
                o.lat = N;
                if (in.b == 0) begin
                    o.lo = '1; o.hi = in.a; o.st = 32'h6;
                end else begin
                    o.lo = in.a / in.b; o.hi = in.a % in.b;
                end
            end
        endcase
    endtask

    // Load operands, start, measure BUSY length, check results and status
    task automatic run_op(input string tag, input vec_t v);
        logic [N-1:0] s, r;
        int lat;
        wr(0, v.a); wr(1, v.b); wr(2, v.c); wr(3, v.d);
        wr(4, {29'd0, v.op, 1'b1});
        rd(5, s);
        chk({tag, ".status_at_start"}, s, 32'h1);
        for (lat = 1; lat <= 500; lat++) begin
            @(posedge i_clk); #1;
            rd(5, s);
            if (s[0] == 1'b0) break;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
        rd(6, r); chk({tag, ".res_lo"}, r, v.lo);
        rd(7, r); chk({tag, ".res_hi"}, r, v.hi);
        rd(5, r); chk({tag, ".status"}, r, v.st);
    endtask

    initial begin
        logic [N-1:0] r;
        vec_t v, e;

        vecs[0] = '{2'b00, 32'd16, 32'd4, 32'd4, 32'd4, 32'd28, 32'd0, 32'h2, 1};
        vecs[1] = '{2'b01, 32'd16, 32'd4, 32'd4, 32'd4, 32'd80, 32'd0, 32'h2, 64};
        vecs[2] = '{2'b10, 32'd16, 32'd4, 32'd4, 32'd4, 32'd4, 32'd0, 32'h2, 32};
        vecs[3] = '{2'b10, 32'd7, 32'd0, 32'd4, 32'd4, 32'hFFFFFFFF, 32'd7, 32'h6, 32};
        vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'd0, 32'h2, 1};
        vecs[5] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd7, 32'd0, 32'h2, 64};
        vecs[6] = '{2'b01, 32'h10000, 32'h10000, 32'd5, 32'd7, 32'd35, 32'd0, 32'h2, 64};
        vecs[7] = '{2'b10, 32'd3, 32'd10, 32'd0, 32'd0, 32'd0, 32'd3, 32'h2, 32};
        vecs[8] = '{2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h2, 32};
        vecs[9] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 32'd0, 32'h2, 32};

        // Reset state
        i_reset = 1'b0; i_RF_WE = 1'b0; i_addr = '0; i_data = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd(32'(k), r);
            chk($sformatf("reset.reg%0d", k), r, 32'd0);
        end

        // Operand write/readback, address aliasing, read-only registers
        wr(0, 32'd16); wr(1, 32'd4); wr(2, 32'd4); wr(3, 32'd4);
        rd(0, r); chk("rb.A", r, 32'd16);
        rd(1, r); chk("rb.B", r, 32'd4);
        rd(2, r); chk("rb.C", r, 32'd4);
        rd(3, r); chk("rb.D", r, 32'd4);
        rd(5, r); chk("rb.status", r, 32'd0);
        rd(8, r); chk("alias.addr8", r, 32'd16);
        wr(6, 32'h1234); wr(5, 32'h7);
        rd(6, r); chk("ro.res_lo", r, 32'd0);
        rd(5, r); chk("ro.status", r, 32'd0);

        // Directed vectors
        for (int k = 0; k < 10; k++) run_op($sformatf("vec%0d", k), vecs[k]);

        // Writes during BUSY are ignored (operand and CTRL)
        wr(0, 32'd16); wr(1, 32'd4); wr(2, 32'd4); wr(3, 32'd4);
        wr(4, 32'h3);
        wr(0, 32'd99);
        wr(4, 32'h5);
        repeat (70) @(posedge i_clk);
        #1;
        rd(0, r); chk("busy.A_kept", r, 32'd16);
        rd(4, r); chk("busy.ctrl_kept", r, 32'h2);
        rd(6, r); chk("busy.mac_res", r, 32'd80);

        // Reserved OP: stored, no start, START reads 0
        wr(4, 32'h7);
        rd(4, r); chk("rsv.ctrl", r, 32'h6);
        rd(5, r); chk("rsv.status", r, 32'h2);
        repeat (3) @(posedge i_clk);
        #1;
        rd(5, r); chk("rsv.status_later", r, 32'h2);

        // Random operations against the reference model
        for (int k = 0; k < 16; k++) begin
            v.op = 2'($urandom_range(0, 2));
            v.a  = (k % 2 == 0) ? $urandom : $urandom_range(0, 300);
            v.b  = (k % 5 == 0) ? 32'd0 : ((k % 2 == 0) ? $urandom : $urandom_range(1, 40));
            v.c  = $urandom;
            v.d  = $urandom;
            model(v, e);
            run_op($sformatf("rnd%0d", k), e);
        end

        // Reset in the middle of a MAC aborts immediately
        wr(0, 32'd5); wr(1, 32'd6); wr(2, 32'd7); wr(3, 32'd8);
        wr(4, 32'h3);
        repeat (9) @(posedge i_clk);
        #2 i_reset = 1'b0;
        rd(5, r); chk("abort.status_async", r, 32'd0);
        for (int k = 0; k < 8; k++) begin
            rd(32'(k), r);
            chk($sformatf("abort.reg%0d", k), r, 32'd0);
        end
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        repeat (70) @(posedge i_clk);
        #1;
        rd(5, r); chk("abort.stays_idle", r, 32'd0);
        rd(6, r); chk("abort.res_lo", r, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
